// File: rtl/preg_release_writer.sv
// Write-side producer for the free physical-register queue: seeds unmapped
// pregs after reset, then buffers committed releases and drains them in order.
module preg_release_writer #(
  parameter int PREG_W    = 7,
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int BUF_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rel_valid_0,
  input  logic [PREG_W-1:0] rel_preg_0,
  input  logic              rel_valid_1,
  input  logic [PREG_W-1:0] rel_preg_1,
  output logic              rel_ready,
  output logic              fq_w_en,
  output logic [PREG_W-1:0] fq_preg_in,
  input  logic              fq_full,
  output logic              init_done,
  output logic              ovf_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PREG_W-1:0]   init_ptr_q, init_ptr_d;
  logic [PREG_W-1:0]   buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, wr1_idx_s;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                run_s, rdy_s, acc0_s, acc1_s, drop_s, wr_s;
  logic [1:0]          acc_n_s;

  // Acceptance, drop detection and write strobe from registered state
  always_comb begin
    run_s   = (state_q == S_RUN);
    rdy_s   = run_s && (count_q <= CNT_W'(BUF_DEPTH - 2));
    acc0_s  = rel_valid_0 && (rel_preg_0 != {PREG_W{1'b0}}) && rdy_s;
    acc1_s  = rel_valid_1 && (rel_preg_1 != {PREG_W{1'b0}}) && rdy_s;
    acc_n_s = {1'b0, acc0_s} + {1'b0, acc1_s};
    // Any release during seeding is lost; in RUN only non-zero ones count
    drop_s  = (rel_valid_0 && (!run_s || ((rel_preg_0 != {PREG_W{1'b0}}) && !rdy_s)))
           || (rel_valid_1 && (!run_s || ((rel_preg_1 != {PREG_W{1'b0}}) && !rdy_s)));
    wr1_idx_s = acc0_s ? (tail_q + PTR_W'(1)) : tail_q;
    if (run_s) begin
      wr_s = (count_q != {CNT_W{1'b0}}) && !fq_full;
    end else begin
      wr_s = !fq_full;
    end
  end

  // Next-state computation for FSM, seed pointer, buffer pointers and flag
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    head_d     = head_q;
    if (!run_s && wr_s) begin
      init_ptr_d = init_ptr_q + PREG_W'(1);
      if (init_ptr_q == PREG_W'(NUM_PREGS - 1)) begin
        state_d = S_RUN;
      end else begin
        state_d = S_INIT;
      end
    end else if (run_s && wr_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    tail_d  = tail_q + PTR_W'(acc_n_s);
    count_d = count_q + CNT_W'(acc_n_s) - CNT_W'(run_s && wr_s);
    ovf_d   = ovf_q | drop_s;
  end

  // State registers and release buffer storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_ptr_q <= PREG_W'(NUM_AREGS);
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= {PREG_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      if (acc0_s) begin
        buf_q[tail_q] <= rel_preg_0;
      end
      if (acc1_s) begin
        buf_q[wr1_idx_s] <= rel_preg_1;
      end
    end
  end

  // Outputs forced quiet while reset is held
  always_comb begin
    rel_ready  = !rst && rdy_s;
    fq_w_en    = !rst && wr_s;
    init_done  = !rst && run_s;
    ovf_err    = !rst && ovf_q;
    if (rst) begin
      fq_preg_in = {PREG_W{1'b0}};
    end else if (!run_s) begin
      fq_preg_in = init_ptr_q;
    end else if (count_q != {CNT_W{1'b0}}) begin
      fq_preg_in = buf_q[head_q];
    end else begin
      fq_preg_in = {PREG_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_preg_release_writer.sv
// Directed self-checking bench for preg_release_writer.
module tb_preg_release_writer;

  logic       clk = 1'b0;
  logic       rst, rel_valid_0, rel_valid_1, fq_full;
  logic [6:0] rel_preg_0, rel_preg_1, fq_preg_in;
  logic       rel_ready, fq_w_en, init_done, ovf_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  preg_release_writer dut (
    .clk(clk), .rst(rst),
    .rel_valid_0(rel_valid_0), .rel_preg_0(rel_preg_0),
    .rel_valid_1(rel_valid_1), .rel_preg_1(rel_preg_1),
    .rel_ready(rel_ready), .fq_w_en(fq_w_en), .fq_preg_in(fq_preg_in),
    .fq_full(fq_full), .init_done(init_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rel(input logic v0, input logic [6:0] p0, input logic v1, input logic [6:0] p1);
    rel_valid_0 = v0; rel_preg_0 = p0; rel_valid_1 = v1; rel_preg_1 = p1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_wen", fq_w_en, 0);
    chk("rst_preg", fq_preg_in, 0);
    chk("rst_ready", rel_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_ovf", ovf_err, 0);
    step();
    rst = 1'b0;
    #1;
  endtask

  // Walk the seeding sequence 32..127, optionally stalling 5 cycles at stall_at
  task automatic run_init(input int stall_at);
    for (int idx = 32; idx < 128; idx++) begin
      if (idx == stall_at) begin
        fq_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("stall_wen", fq_w_en, 0);
          chk("stall_preg", fq_preg_in, 40);
          step();
        end
        fq_full = 1'b0;
        #1;
      end
      chk("seed_wen", fq_w_en, 1);
      chk("seed_preg", fq_preg_in, idx);
      chk("seed_done", init_done, 0);
      chk("seed_ready", rel_ready, 0);
      step();
    end
    chk("init_done", init_done, 1);
    chk("run_idle_wen", fq_w_en, 0);
  endtask

  initial begin
    logic [6:0] exp5 [8];
    rst = 1'b1; fq_full = 1'b0;
    rel_valid_0 = 1'b0; rel_valid_1 = 1'b0; rel_preg_0 = 7'd0; rel_preg_1 = 7'd0;

    // 1: plain seeding
    do_reset();
    run_init(-1);
    // 2: seeding with full stall at 40
    do_reset();
    run_init(40);

    // 3: one pair, drained one per cycle
    set_rel(1'b1, 7'd40, 1'b1, 7'd41);
    chk("t3_ready", rel_ready, 1);
    chk("t3_nobypass", fq_w_en, 0);
    step();
    set_rel(1'b0, 7'd0, 1'b0, 7'd0);
    chk("t3_w1", fq_w_en, 1);
    chk("t3_p1", fq_preg_in, 40);
    step();
    chk("t3_w2", fq_w_en, 1);
    chk("t3_p2", fq_preg_in, 41);
    step();
    chk("t3_w3", fq_w_en, 0);
    chk("t3_p3", fq_preg_in, 0);

    // 4: preg 0 on lane 0 is ignored, lane 1 goes to tail
    set_rel(1'b1, 7'd0, 1'b1, 7'd55);
    step();
    set_rel(1'b0, 7'd0, 1'b0, 7'd0);
    chk("t4_w", fq_w_en, 1);
    chk("t4_p", fq_preg_in, 55);
    step();
    chk("t4_empty", fq_w_en, 0);
    chk("t4_ovf", ovf_err, 0);

    // 5: fill to 8 under full, overflow, then drain in order
    fq_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_rel(1'b1, 7'(60 + 2*k), 1'b1, 7'(61 + 2*k));
      exp5[2*k] = 7'(60 + 2*k);
      exp5[2*k+1] = 7'(61 + 2*k);
      chk("t5_ready", rel_ready, 1);
      chk("t5_wen_full", fq_w_en, 0);
      step();
    end
    set_rel(1'b1, 7'd70, 1'b1, 7'd71);
    chk("t5_ready_low", rel_ready, 0);
    chk("t5_ovf_pre", ovf_err, 0);
    step();
    set_rel(1'b0, 7'd0, 1'b0, 7'd0);
    chk("t5_ovf", ovf_err, 1);
    fq_full = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t5_dw", fq_w_en, 1);
      chk("t5_dp", fq_preg_in, exp5[k]);
      step();
    end
    chk("t5_end_wen", fq_w_en, 0);
    chk("t5_ovf_sticky", ovf_err, 1);

    // 6: reset with 3 buffered entries discards them
    fq_full = 1'b1;
    set_rel(1'b1, 7'd80, 1'b1, 7'd81);
    step();
    set_rel(1'b1, 7'd82, 1'b0, 7'd0);
    step();
    set_rel(1'b0, 7'd0, 1'b0, 7'd0);
    chk("t6_held", fq_w_en, 0);
    do_reset();
    fq_full = 1'b0;
    #1;
    chk("t6_ovf", ovf_err, 0);
    run_init(-1);
    step();
    chk("t6_no_stale", fq_w_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
